serial_adder_ctrl: RTL and testbench



---
 rtl/serial_adder_ctrl_if.sv | 31 +++
 rtl/serial_adder_ctrl.sv | 134 +++++++++++++
 tb/tb_serial_adder_ctrl.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_ctrl_if
// Description : Request/result bundle for the bit-serial adder controller.
//               The master issues start/a/b (and sub when built with
//               SERIAL_ADDER_SUB_EN); the slave returns busy/done/sum/carry_out.
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_adder_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry_out;

`ifdef SERIAL_ADDER_SUB_EN
  modport master (output start, a, b, sub, input busy, done, sum, carry_out);
  modport slave  (input start, a, b, sub, output busy, done, sum, carry_out);
`else
  modport master (output start, a, b, input busy, done, sum, carry_out);
  modport slave  (input start, a, b, output busy, done, sum, carry_out);
`endif
endinterface
`default_nettype wire

// File: rtl/serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_ctrl
// Description : Bit-serial adder. One full-adder cell (two half adders plus
//               an OR of their carries) is stepped over WIDTH cycles, LSB
//               first, with a carry flip-flop chaining the bits. Result and
//               final carry are registered out on entry to DONE and held
//               until the next result.
//               Optional macro SERIAL_ADDER_SUB_EN adds a 'sub' request bit
//               that computes a-b (B inverted, carry-in forced to 1).
// Revision    : 1.0 - initial release
// ============================================================================
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_adder_ctrl_if.slave   bus
);

  localparam int              CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]   LAST_BIT = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Half-adder primitive: returns {carry, sum}
  function automatic logic [1:0] half_add(input logic x, input logic y);
    return {x & y, x ^ y};
  endfunction

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  // Holds the WIDTH-1 most recently produced sum bits, newest at the MSB;
  // the final bit is merged in combinationally when the result is captured.
  logic [WIDTH-2:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic [1:0]       w_ha0, w_ha1;
  logic             w_cell_sum;
  logic             w_cell_carry;
  logic [WIDTH-1:0] w_res_shift;
  logic             w_sub;

`ifdef SERIAL_ADDER_SUB_EN
  assign w_sub = bus.sub;
`else
  assign w_sub = 1'b0;
`endif

  // Full-adder cell built from two half adders; carries combine with OR
  assign w_ha0        = half_add(opa_q[0], opb_q[0]);
  assign w_ha1        = half_add(w_ha0[0], carry_q);
  assign w_cell_sum   = w_ha1[0];
  assign w_cell_carry = w_ha0[1] | w_ha1[1];
  assign w_res_shift  = {w_cell_sum, res_q};

  // Next-state and datapath sequencing for IDLE/RUN/DONE
  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_RUN;
          opa_d   = bus.a;
          // Subtraction is a + ~b + 1: invert B and seed the carry with 1
          opb_d   = bus.b ^ {WIDTH{w_sub}};
          carry_d = w_sub;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        opa_d   = {1'b0, opa_q[WIDTH-1:1]};
        opb_d   = {1'b0, opb_q[WIDTH-1:1]};
        res_d   = w_res_shift[WIDTH-1:1];
        carry_d = w_cell_carry;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
          state_d = S_DONE;
          sum_d   = w_res_shift;
          cout_d  = w_cell_carry;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers, asynchronously cleared
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign bus.busy      = (state_q == S_RUN) || (state_q == S_DONE);
  assign bus.done      = (state_q == S_DONE);
  assign bus.sum       = sum_q;
  assign bus.carry_out = cout_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_adder_ctrl
// Description : Self-checking bench for serial_adder_ctrl: directed vector
//               table, randomized operations against an arithmetic model,
//               held-start throughput and mid-run asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder_ctrl;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    bit           pulse;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_adder_ctrl_if #(.WIDTH(W)) bus ();

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_pass  = 0;
  int n_total = 0;
  logic [W-1:0] prev_sum  = '0;
  logic         prev_cout = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Arithmetic reference: {carry_out, sum}
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic sub);
    int unsigned t;
    if (sub) begin
      t = (int'(a) - int'(b)) & ((1 << W) - 1);
      return {(a >= b), t[W-1:0]};
    end
    t = int'(a) + int'(b);
    return {(t >= (1 << W)), t[W-1:0]};
  endfunction

  task automatic drive_ops(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    bus.a = a;
    bus.b = b;
`ifdef SERIAL_ADDER_SUB_EN
    bus.sub = s;
`else
    if (s) $display("note: sub request ignored in this build");
`endif
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input bit pulse, input logic [W-1:0] exp_sum,
                        input logic exp_cout, input string tag);
    int lat;
    bit seen;
    @(negedge clk);
    bus.start = 1'b1;
    drive_ops(a, b, s);
    tick;
    bus.start = 1'b0;
    drive_ops(W'($urandom), W'($urandom), 1'($urandom));
    check({tag, " busy@accept"}, bus.busy, 1);
    lat  = 0;
    seen = 0;
    while (!seen && lat < W + 4) begin
      if (pulse && lat == 2) begin
        bus.start = 1'b1;
        drive_ops('1, '1, 1'b0);
      end else begin
        bus.start = 1'b0;
      end
      tick;
      lat++;
      if (bus.done) seen = 1;
      else begin
        check({tag, " hold sum"}, bus.sum, prev_sum);
        check({tag, " hold cout"}, bus.carry_out, prev_cout);
        check({tag, " busy run"}, bus.busy, 1);
      end
    end
    bus.start = 1'b0;
    check({tag, " latency"}, lat, W);
    if (seen) begin
      check({tag, " sum"}, bus.sum, exp_sum);
      check({tag, " cout"}, bus.carry_out, exp_cout);
      check({tag, " busy done"}, bus.busy, 1);
    end
    prev_sum  = exp_sum;
    prev_cout = exp_cout;
    tick;
    check({tag, " done pulse end"}, bus.done, 0);
    check({tag, " idle busy"}, bus.busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[$];
    logic [W:0] m;
    logic [W-1:0] ra, rb;
    logic rs;
    int cyc, gap;

    bus.start = 1'b0;
    drive_ops('0, '0, 1'b0);

    tbl.push_back('{a:8'h00, b:8'h00, sub:1'b0, pulse:0, exp_sum:8'h00, exp_cout:1'b0});
    tbl.push_back('{a:8'hFF, b:8'h01, sub:1'b0, pulse:0, exp_sum:8'h00, exp_cout:1'b1});
    tbl.push_back('{a:8'h5A, b:8'hA5, sub:1'b0, pulse:0, exp_sum:8'hFF, exp_cout:1'b0});
    tbl.push_back('{a:8'h80, b:8'h80, sub:1'b0, pulse:0, exp_sum:8'h00, exp_cout:1'b1});
    tbl.push_back('{a:8'h12, b:8'h34, sub:1'b0, pulse:1, exp_sum:8'h46, exp_cout:1'b0});
`ifdef SERIAL_ADDER_SUB_EN
    tbl.push_back('{a:8'h10, b:8'h01, sub:1'b1, pulse:0, exp_sum:8'h0F, exp_cout:1'b1});
    tbl.push_back('{a:8'h01, b:8'h02, sub:1'b1, pulse:0, exp_sum:8'hFF, exp_cout:1'b0});
`endif

    // Reset state
    repeat (3) tick;
    check("reset busy", bus.busy, 0);
    check("reset done", bus.done, 0);
    check("reset sum", bus.sum, 0);
    check("reset cout", bus.carry_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick;
    check("post-reset idle busy", bus.busy, 0);

    // Directed vectors
    for (int i = 0; i < tbl.size(); i++) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].sub, tbl[i].pulse,
             tbl[i].exp_sum, tbl[i].exp_cout, $sformatf("vec%0d", i));
    end

    // Randomized operations against the arithmetic model
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      if (i % 8 == 0) rb = ra;
      m = model(ra, rb, rs);
      run_op(ra, rb, rs, (i % 5 == 0), m[W-1:0], m[W], $sformatf("rnd%0d", i));
    end

    // start held high: back-to-back operations every W+2 cycles
    @(negedge clk);
    bus.start = 1'b1;
    drive_ops(8'h03, 8'h04, 1'b0);
    cyc = 0;
    do begin tick; cyc++; end while (!bus.done && cyc < 30);
    check("held first done", bus.done, 1);
    check("held first sum", bus.sum, 8'h07);
    gap = 0;
    do begin tick; gap++; end while (!bus.done && gap < 30);
    bus.start = 1'b0;
    check("held throughput", gap, W + 2);
    check("held second sum", bus.sum, 8'h07);
    tick;
    check("held then idle", bus.busy, 0);

    // Asynchronous reset in the middle of RUN
    @(negedge clk);
    bus.start = 1'b1;
    drive_ops(8'hF0, 8'h0F, 1'b0);
    tick;
    bus.start = 1'b0;
    repeat (4) tick;
    check("pre-reset busy", bus.busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst busy", bus.busy, 0);
    check("async rst done", bus.done, 0);
    check("async rst sum", bus.sum, 0);
    check("async rst cout", bus.carry_out, 0);
    cyc = 0;
    for (int k = 0; k < W + 2; k++) begin
      tick;
      if (bus.done) cyc++;
    end
    check("no done under reset", cyc, 0);
    @(negedge clk);
    rst_n = 1'b1;
    prev_sum  = '0;
    prev_cout = 1'b0;
    tick;
    check("after release idle", bus.busy, 0);
    run_op(8'h01, 8'h02, 1'b0, 0, 8'h03, 1'b0, "post-reset");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
